// File: rtl/ifu_prefetch_if.sv
// Fetch-stage signal bundle: redirect inputs, instruction bus (req/gnt/rvalid)
// and the valid/ready handshake towards the if_id register.
// The prefetcher connects through the master modport; the bus and decoder
// side (or a testbench standing in for them) uses the slave modport.
interface ifu_prefetch_if;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;

  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;

  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_ready_i;

  modport master (
    input  jump_flag_i,
    input  jump_addr_i,
    output ibus_req_o,
    output ibus_addr_o,
    input  ibus_gnt_i,
    input  ibus_rvalid_i,
    input  ibus_rdata_i,
    output inst_valid_o,
    output inst_o,
    output inst_addr_o,
    input  inst_ready_i
  );

  modport slave (
    output jump_flag_i,
    output jump_addr_i,
    input  ibus_req_o,
    input  ibus_addr_o,
    output ibus_gnt_i,
    output ibus_rvalid_i,
    output ibus_rdata_i,
    input  inst_valid_o,
    input  inst_o,
    input  inst_addr_o,
    output inst_ready_i
  );
endinterface

// File: rtl/ifu_prefetch.sv
// Instruction prefetch stage. Issues in-order fetches on the instruction bus,
// buffers returned words together with their PCs in a DEPTH-entry FIFO and
// hands them to if_id over valid/ready. A jump flushes the FIFO, restarts
// fetch at the target and marks every response still in flight for discard.
// Buffered plus in-flight fetches never exceed DEPTH, so a returning word
// always has a FIFO slot waiting for it.
module ifu_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic            clk,
  input logic            rst_n,
  ifu_prefetch_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] fifo_count;
  logic [AW-1:0] fifo_wr;
  logic [AW-1:0] fifo_rd;
  logic [AW-1:0] pcq_wr;
  logic [AW-1:0] pcq_rd;

  logic [31:0] fifo_inst [DEPTH];
  logic [31:0] fifo_pc   [DEPTH];
  logic [31:0] pcq       [DEPTH];

  logic [CW:0]   credit_used;
  logic          credit_ok;
  logic          req;
  logic          fire;
  logic          rsp;
  logic          rsp_keep;
  logic          push;
  logic          pop;
  logic          head_valid;
  logic [CW-1:0] outstanding_next;

  // Credit, handshake qualifiers and the in-flight count after this cycle.
  // A response with nothing outstanding is a bus error and is not counted.
  // During a jump nothing is requested, nothing is pushed and a pop is ignored.
  always_comb begin
    credit_used      = {1'b0, fifo_count} + {1'b0, outstanding};
    credit_ok        = credit_used < DEPTH_C;
    req              = rst_n & ~bus.jump_flag_i & credit_ok;
    fire             = req & bus.ibus_gnt_i;
    rsp              = bus.ibus_rvalid_i & (outstanding != '0);
    rsp_keep         = rsp & (discard == '0);
    push             = rsp_keep & ~bus.jump_flag_i;
    head_valid       = (fifo_count != '0);
    pop              = head_valid & bus.inst_ready_i & ~bus.jump_flag_i;
    outstanding_next = outstanding + CW'(fire) - CW'(rsp);
  end

  // Fetch address, bus bookkeeping and FIFO/PC-queue pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      fifo_count  <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (bus.jump_flag_i) begin
        fetch_pc   <= bus.jump_addr_i;
        discard    <= outstanding_next;
        fifo_count <= '0;
        fifo_wr    <= '0;
        fifo_rd    <= '0;
        pcq_wr     <= '0;
        pcq_rd     <= '0;
      end else begin
        if (fire) begin
          fetch_pc <= fetch_pc + 32'd4;
          pcq_wr   <= pcq_wr + AW'(1);
        end
        if (rsp && (discard != '0)) begin
          discard <= discard - CW'(1);
        end
        if (push) begin
          fifo_wr <= fifo_wr + AW'(1);
          pcq_rd  <= pcq_rd + AW'(1);
        end
        if (pop) begin
          fifo_rd <= fifo_rd + AW'(1);
        end
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage: PC of each granted fetch, then {word, pc} once the word returns.
  always_ff @(posedge clk) begin
    if (fire) begin
      pcq[pcq_wr] <= fetch_pc;
    end
    if (push) begin
      fifo_inst[fifo_wr] <= bus.ibus_rdata_i;
      fifo_pc[fifo_wr]   <= pcq[pcq_rd];
    end
  end

  // Bus request and head-of-FIFO presentation; NOP at pc 0 when empty.
  always_comb begin
    bus.ibus_req_o   = req;
    bus.ibus_addr_o  = fetch_pc;
    bus.inst_valid_o = head_valid;
    bus.inst_o       = head_valid ? fifo_inst[fifo_rd] : NOP;
    bus.inst_addr_o  = head_valid ? fifo_pc[fifo_rd] : 32'h0000_0000;
  end

  // A response with no fetch outstanding means the bus broke protocol.
  rvalid_has_outstanding : assert property (
    @(posedge clk) disable iff (!rst_n) bus.ibus_rvalid_i |-> (outstanding != '0));

  // Credit must keep the FIFO from ever overflowing.
  push_has_room : assert property (
    @(posedge clk) disable iff (!rst_n) (push && !pop) |-> (fifo_count < DEPTH_C[CW-1:0]));

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch (DEPTH=2). A bus responder grants/returns words,
// the stimulus thread queues expected {inst, pc} pairs, and a monitor pops
// and compares them whenever the prefetcher hands a word to the decoder.
module tb_ifu_prefetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  logic clk;
  logic rst_n;
  logic gnt_en;
  logic resp_en;
  int   grant_cnt;
  int   checks;
  int   failures;

  exp_t        exp_q[$];
  logic [31:0] pending[$];

  ifu_prefetch_if bus();

  ifu_prefetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_t e;
    e.inst = inst_of(pc);
    e.pc   = pc;
    exp_q.push_back(e);
  endtask

  // Let the decoder take words until every expected one is gone, then stall.
  task automatic drain_then_stall(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    bus.inst_ready_i = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got=%0d words left exp=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Bus responder: returns one queued word per cycle when enabled, grants
  // whenever enabled and requested; responses come at least a cycle after gnt.
  initial begin
    logic [31:0] a;
    bus.ibus_gnt_i    = 1'b0;
    bus.ibus_rvalid_i = 1'b0;
    bus.ibus_rdata_i  = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        pending.delete();
        bus.ibus_rvalid_i = 1'b0;
        bus.ibus_gnt_i    = 1'b0;
      end else begin
        if (resp_en && pending.size() > 0) begin
          a = pending.pop_front();
          bus.ibus_rvalid_i = 1'b1;
          bus.ibus_rdata_i  = inst_of(a);
        end else begin
          bus.ibus_rvalid_i = 1'b0;
          bus.ibus_rdata_i  = 32'h0;
        end
        bus.ibus_gnt_i = gnt_en;
        if (gnt_en && bus.ibus_req_o) begin
          pending.push_back(bus.ibus_addr_o);
          grant_cnt++;
        end
      end
    end
  end

  // Monitor: every accepted word must match the head of the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.inst_valid_o && bus.inst_ready_i && !bus.jump_flag_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pop got pc=%h inst=%h exp=none", bus.inst_addr_o, bus.inst_o);
        end else begin
          e = exp_q.pop_front();
          chk("pop_inst", bus.inst_o, e.inst);
          chk("pop_pc", bus.inst_addr_o, e.pc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    checks    = 0;
    failures  = 0;
    grant_cnt = 0;
    rst_n     = 1'b0;
    gnt_en    = 1'b1;
    resp_en   = 1'b1;
    bus.jump_flag_i  = 1'b0;
    bus.jump_addr_i  = 32'h0;
    bus.inst_ready_i = 1'b0;

    // 1: reset values, then in-order stream from RESET_PC
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", 32'(bus.ibus_req_o), 32'd0);
    chk("rst_valid", 32'(bus.inst_valid_o), 32'd0);
    chk("rst_inst", bus.inst_o, NOP);
    chk("rst_addr", bus.inst_addr_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.inst_ready_i = 1'b1;
    #1;
    chk("first_req", 32'(bus.ibus_req_o), 32'd1);
    chk("first_addr", bus.ibus_addr_o, 32'h0);
    for (int i = 0; i < 6; i++) expect_pc(32'(i * 4));
    drain_then_stall("stream");

    // 2: backpressure; DEPTH caps buffered + in-flight fetches
    repeat (6) @(negedge clk);
    chk("t2_full_valid", 32'(bus.inst_valid_o), 32'd1);
    bus.jump_flag_i = 1'b1;
    bus.jump_addr_i = 32'h200;
    g0 = grant_cnt;
    @(negedge clk);
    bus.jump_flag_i = 1'b0;
    repeat (6) @(negedge clk);
    chk("t2_grants", 32'(grant_cnt - g0), 32'd2);
    chk("t2_req_off", 32'(bus.ibus_req_o), 32'd0);
    chk("t2_head", bus.inst_addr_o, 32'h200);
    expect_pc(32'h200);
    bus.inst_ready_i = 1'b1;
    @(negedge clk);
    bus.inst_ready_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("t2_grants_after_pop", 32'(grant_cnt - g0), 32'd3);
    chk("t2_req_off2", 32'(bus.ibus_req_o), 32'd0);
    chk("t2_head2", bus.inst_addr_o, 32'h204);
    chk("t2_popped", 32'(exp_q.size()), 32'd0);

    // 3: two fetches in flight at jump are both dropped
    @(negedge clk);
    bus.jump_flag_i = 1'b1;
    bus.jump_addr_i = 32'h10;
    resp_en = 1'b0;
    #1;
    chk("t3_valid_during_jump", 32'(bus.inst_valid_o), 32'd1);
    chk("t3_req_during_jump", 32'(bus.ibus_req_o), 32'd0);
    @(negedge clk);
    bus.jump_flag_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("t3_req_capped", 32'(bus.ibus_req_o), 32'd0);
    chk("t3_next_addr", bus.ibus_addr_o, 32'h18);
    @(negedge clk);
    bus.jump_flag_i = 1'b1;
    bus.jump_addr_i = 32'h100;
    #1;
    chk("t3_req_jump", 32'(bus.ibus_req_o), 32'd0);
    @(negedge clk);
    bus.jump_flag_i = 1'b0;
    resp_en = 1'b1;
    #1;
    chk("t3_flushed_valid", 32'(bus.inst_valid_o), 32'd0);
    chk("t3_flushed_inst", bus.inst_o, NOP);
    chk("t3_flushed_addr", bus.inst_addr_o, 32'h0);
    expect_pc(32'h100);
    expect_pc(32'h104);
    expect_pc(32'h108);
    bus.inst_ready_i = 1'b1;
    drain_then_stall("after_jump");

    // 4: jump coincident with rvalid and ready
    repeat (6) @(negedge clk);
    bus.jump_flag_i = 1'b1;
    bus.jump_addr_i = 32'h300;
    resp_en = 1'b0;
    @(negedge clk);
    bus.jump_flag_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("t4_req_capped", 32'(bus.ibus_req_o), 32'd0);
    chk("t4_empty", 32'(bus.inst_valid_o), 32'd0);
    @(negedge clk);
    bus.jump_flag_i = 1'b1;
    bus.jump_addr_i = 32'h400;
    bus.inst_ready_i = 1'b1;
    resp_en = 1'b1;
    @(negedge clk);
    bus.jump_flag_i = 1'b0;
    expect_pc(32'h400);
    expect_pc(32'h404);
    expect_pc(32'h408);
    #1;
    chk("t4_valid_after", 32'(bus.inst_valid_o), 32'd0);
    chk("t4_inst_after", bus.inst_o, NOP);
    drain_then_stall("jump_rvalid");

    // 5: fetch address wraps past 0xFFFF_FFFC
    repeat (6) @(negedge clk);
    bus.jump_flag_i = 1'b1;
    bus.jump_addr_i = 32'hFFFF_FFFC;
    @(negedge clk);
    bus.jump_flag_i = 1'b0;
    #1;
    chk("t5_top_addr", bus.ibus_addr_o, 32'hFFFF_FFFC);
    chk("t5_top_req", 32'(bus.ibus_req_o), 32'd1);
    @(negedge clk);
    #1;
    chk("t5_wrap_addr", bus.ibus_addr_o, 32'h0);
    expect_pc(32'hFFFF_FFFC);
    expect_pc(32'h0);
    expect_pc(32'h4);
    bus.inst_ready_i = 1'b1;
    drain_then_stall("wrap");

    // 6: asynchronous reset with the FIFO full
    repeat (6) @(negedge clk);
    chk("t6_full_valid", 32'(bus.inst_valid_o), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req", 32'(bus.ibus_req_o), 32'd0);
    chk("t6_rst_valid", 32'(bus.inst_valid_o), 32'd0);
    chk("t6_rst_inst", bus.inst_o, NOP);
    chk("t6_rst_addr", bus.inst_addr_o, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.inst_ready_i = 1'b1;
    #1;
    chk("t6_refetch_req", 32'(bus.ibus_req_o), 32'd1);
    chk("t6_refetch_addr", bus.ibus_addr_o, 32'h0);
    expect_pc(32'h0);
    expect_pc(32'h4);
    expect_pc(32'h8);
    drain_then_stall("refetch");

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
